// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Brief    : Pipeline stall bus generator with a multi-cycle execute sequencer.
//            Optional stall-cycle statistics counter under PIPE_STALL_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        flush_i,
    input  logic        mc_start_i,
    input  logic [5:0]  mc_cycles_i,
    output logic [5:0]  stall_o,
    output logic        mc_busy_o,
    output logic        mc_done_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [5:0] C_STALL_NONE = 6'b000000;
    localparam logic [5:0] C_STALL_ID   = 6'b000111;
    localparam logic [5:0] C_STALL_EX   = 6'b001111;
    localparam logic [5:0] C_STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_nxt;
    logic       w_run;
    logic       w_done_st;
    logic       w_seq_stall;
    logic       w_ex_stall;

    // Sequencer-derived terms are masked during reset so outputs read idle at once.
    assign w_run       = (r_state == S_RUN)  && !rst;
    assign w_done_st   = (r_state == S_DONE) && !rst;
    assign w_seq_stall = w_run || (!rst && (r_state == S_IDLE) && mc_start_i)
                       || (w_done_st && stallreq_mem_i);
    assign w_ex_stall  = stallreq_ex_i || w_seq_stall;

    assign mc_busy_o   = w_run;
    assign mc_done_o   = w_done_st && !flush_i;

    always_comb begin
        stall_o = C_STALL_NONE;
        if (flush_i)
            stall_o = C_STALL_NONE;
        else if (stallreq_mem_i)
            stall_o = C_STALL_MEM;
        else if (w_ex_stall)
            stall_o = C_STALL_EX;
        else if (stallreq_id_i)
            stall_o = C_STALL_ID;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (mc_start_i) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = (mc_cycles_i == 6'd0) ? 6'd1 : mc_cycles_i;
                end
            end
            S_RUN: begin
                if (r_cnt == 6'd1) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = 6'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 6'd1;
                end
            end
            S_DONE: begin
                // Result is held until the execute stage is allowed to advance.
                if (!stall_o[3])
                    w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 6'd0;
            end
        endcase
        if (flush_i) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 6'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef PIPE_STALL_STAT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= 32'h0;
        else if (stall_o[0] && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'h1;
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 32'h0;
`endif

endmodule
`default_nettype wire
